// File: rtl/pipe_stage_ctrl_if.sv
// Bundle between the hazard/fetch/decode side (master) and the pipeline register block (slave).
// Carries stall/flush/redirect controls, decode operands in, and registered D/E-stage state out.
interface pipe_stage_ctrl_if #(
    parameter int XLEN = 32
);
    logic            stallf;
    logic            stalld;
    logic            flushe;
    logic            pcsrc_d;
    logic [XLEN-1:0] pc_branch_d;
    logic [31:0]     instr_f;
    logic [XLEN-1:0] pc_f;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_d;
    logic [7:0]      ctrl_d;
    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;
    logic [XLEN-1:0] signimm_d;
    logic [4:0]      rs_d;
    logic [4:0]      rt_d;
    logic [4:0]      rd_d;
    logic            reg_write_e;
    logic            memtoreg_e;
    logic            memwrite_e;
    logic            alusrc_e;
    logic            regdst_e;
    logic [2:0]      alu_ctrl_e;
    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    logic [XLEN-1:0] signimm_e;
    logic [4:0]      rs_e;
    logic [4:0]      rt_e;
    logic [4:0]      rd_e;
    logic            valid_e;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;

    modport master (
        output stallf, stalld, flushe, pcsrc_d, pc_branch_d, instr_f,
               ctrl_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
        input  pc_f, instr_d, pc_plus4_d, valid_d,
               reg_write_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alu_ctrl_e,
               rd1_e, rd2_e, signimm_e, rs_e, rt_e, rd_e, valid_e,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  stallf, stalld, flushe, pcsrc_d, pc_branch_d, instr_f,
               ctrl_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
        output pc_f, instr_d, pc_plus4_d, valid_d,
               reg_write_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alu_ctrl_e,
               rd1_e, rd2_e, signimm_e, rs_e, rt_e, rd_e, valid_e,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// PC, IF/ID and ID/EX registers; all outputs registered, stall/flush/redirect act at the next edge, no backpressure beyond holding.
// Define PIPE_PERF_CNT_EN to build saturating stall/flush event counters; otherwise they read constant 0.
module pipe_stage_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pipe_stage_ctrl_if.slave bus
);
    typedef struct packed {
        logic [7:0]      ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic            valid;
    } idex_t;

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_d_q;
    logic [XLEN-1:0] pc_plus4_d_q;
    logic            valid_d_q;
    idex_t           idex_q;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    // stallf outranks a redirect: the fetch slot is frozen regardless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (!bus.stallf) begin
            pc_q <= bus.pcsrc_d ? bus.pc_branch_d : pc_plus4;
        end
    end

    // A stalled branch resolves on stale operands, so stalld masks pcsrc_d
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d_q    <= '0;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
        end else if (!bus.stalld) begin
            if (bus.pcsrc_d) begin
                instr_d_q    <= '0;
                pc_plus4_d_q <= '0;
                valid_d_q    <= 1'b0;
            end else begin
                instr_d_q    <= bus.instr_f;
                pc_plus4_d_q <= pc_plus4;
                valid_d_q    <= 1'b1;
            end
        end
    end

    // All-zero bubble: rs/rt of 0 cannot match forwarding compares, no write enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else if (bus.flushe) begin
            idex_q <= '0;
        end else begin
            idex_q <= '{ctrl: bus.ctrl_d, rd1: bus.rd1_d, rd2: bus.rd2_d, imm: bus.signimm_d,
                        rs: bus.rs_d, rt: bus.rt_d, rd: bus.rd_d, valid: valid_d_q};
        end
    end

    assign bus.pc_f        = pc_q;
    assign bus.instr_d     = instr_d_q;
    assign bus.pc_plus4_d  = pc_plus4_d_q;
    assign bus.valid_d     = valid_d_q;
    assign bus.reg_write_e = idex_q.ctrl[7];
    assign bus.memtoreg_e  = idex_q.ctrl[6];
    assign bus.memwrite_e  = idex_q.ctrl[5];
    assign bus.alusrc_e    = idex_q.ctrl[4];
    assign bus.regdst_e    = idex_q.ctrl[3];
    assign bus.alu_ctrl_e  = idex_q.ctrl[2:0];
    assign bus.rd1_e       = idex_q.rd1;
    assign bus.rd2_e       = idex_q.rd2;
    assign bus.signimm_e   = idex_q.imm;
    assign bus.rs_e        = idex_q.rs;
    assign bus.rt_e        = idex_q.rt;
    assign bus.rd_e        = idex_q.rd;
    assign bus.valid_e     = idex_q.valid;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        flush_evt;

    // flushe and an accepted redirect in the same cycle count once
    assign flush_evt = bus.flushe | (bus.pcsrc_d & ~bus.stalld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.stalld && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Front-end pipeline register block that applies the stall and flush decisions produced by the hazard unit. It owns the fetch PC register, the IF/ID register and the ID/EX register. It sits between fetch, decode and execute. Its E-stage outputs (`rs_e`, `rt_e`, `writereg`-relevant fields, `reg_write_e`, `memtoreg_e`) feed back into the hazard unit, which closes the loop.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stallf`  in  1  hold PC
- `stalld`  in  1  hold IF/ID
- `flushe`  in  1  load a bubble into ID/EX
- `pcsrc_d`  in  1  branch taken in decode; redirect PC and flush IF/ID
- `pc_branch_d`  in  XLEN  branch target
- `instr_f`  in  32  fetched instruction
- `pc_f`  out  XLEN  current fetch PC
- `instr_d`  out  32  IF/ID instruction
- `pc_plus4_d`  out  XLEN  IF/ID PC+4
- `valid_d`  out  1  IF/ID holds a real instruction
- `ctrl_d`  in  8  {reg_write, memtoreg, memwrite, alusrc, regdst, alu_ctrl[2:0]}
- `rd1_d`, `rd2_d`, `signimm_d`  in  XLEN  decode operands
- `rs_d`, `rt_d`, `rd_d`  in  5  decode register fields
- `reg_write_e`, `memtoreg_e`, `memwrite_e`, `alusrc_e`, `regdst_e`  out  1  ID/EX control
- `alu_ctrl_e`  out  3  ID/EX ALU control
- `rd1_e`, `rd2_e`, `signimm_e`  out  XLEN  ID/EX operands
- `rs_e`, `rt_e`, `rd_e`  out  5  ID/EX register fields
- `valid_e`  out  1  ID/EX holds a real instruction
- `stall_cnt`  out  32  decode-stall cycle counter (see Configuration)
- `flush_cnt`  out  32  bubble/flush event counter (see Configuration)

## Operation
PC register, evaluated in priority order:
- `rst`: load `RESET_PC`.
- `stallf=1`: hold. This has priority over `pcsrc_d`.
- `pcsrc_d=1`: load `pc_branch_d`.
- Otherwise: load `pc_f+4`, wrapping modulo 2^XLEN.

IF/ID register, evaluated in priority order:
- `rst`: all fields 0, `valid_d=0`.
- `stalld=1`: hold. This has priority over `pcsrc_d`, because a stalled branch's `pcsrc_d` is computed from stale operands and is ignored.
- `pcsrc_d=1`: `instr_d=32'h0` (NOP), `pc_plus4_d=0`, `valid_d=0`.
- Otherwise: capture `instr_f`, `pc_f+4`, and set `valid_d=1`.

ID/EX register, evaluated in priority order:
- `rst` or `flushe=1`: every field 0 and `valid_e=0`.
  - `rs_e`/`rt_e`=0 guarantees the bubble never matches a forwarding or load-use compare.
  - `reg_write_e`=`memtoreg_e`=`memwrite_e`=0 guarantees the bubble has no side effects.
- Otherwise: capture all decode inputs and set `valid_e=valid_d`. A flushed IF/ID slot therefore propagates as a bubble.

`stalld` does not freeze ID/EX. The hazard unit always pairs `stalld` with `flushe`. If `stalld=1` and `flushe=0`, ID/EX captures the held decode contents (a duplicate issue). That combination is illegal and is not checked.

## Timing
- Reset values: `pc_f=RESET_PC`. Every other output is 0, including `valid_d`, `valid_e` and both counters.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Stall, flush and redirect take effect at the next rising edge, so one-cycle latency.
- A branch taken in D at cycle n gives `pc_f=pc_branch_d` at n+1 and a bubble in IF/ID at n+1. The penalty is 1 slot.
- A load-use stall (`stallf`=`stalld`=`flushe`=1 for 1 cycle) gives:
  - `pc_f` and `instr_d` unchanged at n+1;
  - `valid_e=0` at n+1;
  - the dependent instruction entering EX at n+2.
- Reset asserted mid-operation clears all state asynchronously. The first fetch after deassertion is at `RESET_PC`.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` increments every cycle with `stalld=1`.
  - `flush_cnt` increments every cycle with `flushe=1` or with an accepted `pcsrc_d` (`pcsrc_d=1` and `stalld=0`); this is one increment per cycle even when both occur.
  - Both counters saturate at 32'hFFFF_FFFF and clear on `rst`.
- `PIPE_PERF_CNT_EN` undefined: no counter flops are built, and `stall_cnt` and `flush_cnt` are constant 0.

## Test plan
- Reset release, no stalls, `instr_f` streaming: `pc_f` = 0, 4, 8, 12. `valid_d` goes to 1 one cycle after the first fetch. `valid_e` goes to 1 one cycle later.
- `pcsrc_d=1`, `pc_branch_d=32'h40`, with `pc_f=32'h10`: next cycle `pc_f=32'h40`, `instr_d=0`, `valid_d=0`. The cycle after, `valid_e=0`.
- Load-use, with `stallf`=`stalld`=`flushe`=1 for one cycle at `pc_f=32'h20`, `rs_d=5`: next cycle `pc_f=32'h20`, `instr_d` held, `rs_e=0`, `memtoreg_e=0`. The following cycle `rs_e=5`.
- `stalld=1` together with `pcsrc_d=1`: PC held (`stallf=1`), `instr_d` held, no redirect. Once the stall is released with `pcsrc_d` still 1, the redirect occurs.
- `rst` asserted asynchronously mid-stream, between clock edges: `pc_f=RESET_PC`, and all E and D outputs are 0 immediately, without waiting for a clock edge.
- With `PIPE_PERF_CNT_EN` defined, 3 stall cycles plus 2 branch flushes give `stall_cnt=3` and `flush_cnt=5` (each stall cycle also asserts `flushe`). With the macro undefined, both counters read 0.
